// File: rtl/alu_result_capture_16b_if.sv
// alu_result_capture_16b_if: bundle between ALU control, the 3-to-1 result mux and the result consumer.
//   op_valid/op_sel/op_ready        : select op handshake from ALU control
//   sel_in0/sel_in1/mux_out         : mux select drive and mux result
//   res_valid/res_ready/res_*       : captured-result FIFO head handshake
//   busy                            : capture stage is waiting for the mux to settle
//   slave modport is the capture stage, master modport is its environment.
interface alu_result_capture_16b_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic [1:0]       op_sel;
    logic             op_ready;
    logic             sel_in0;
    logic             sel_in1;
    logic [WIDTH-1:0] mux_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_neg;
    logic [1:0]       res_sel;
    logic             busy;
    modport slave (
        input  op_valid, op_sel, mux_out, res_ready,
        output op_ready, sel_in0, sel_in1, res_valid, res_data, res_zero, res_neg, res_sel, busy
    );
    modport master (
        output op_valid, op_sel, mux_out, res_ready,
        input  op_ready, sel_in0, sel_in1, res_valid, res_data, res_zero, res_neg, res_sel, busy
    );
endinterface

// File: rtl/alu_result_capture_16b.sv
// alu_result_capture_16b: drives the ALU result mux selects, waits SETTLE cycles, captures mux_out with zero/neg flags into a DEPTH-entry FIFO.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of alu_result_capture_16b_if (op handshake, mux selects/result, result FIFO head, busy)
module alu_result_capture_16b #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 2,
    parameter int DEPTH  = 2
) (
    input logic                     clk,
    input logic                     rst,
    alu_result_capture_16b_if.slave bus
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 4;
    localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [NW-1:0] FULL     = NW'(DEPTH);
    typedef enum logic {IDLE, SETTLE_S} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [NW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic          accept, push, pop;
    // The selects are held from accept until the next accept, so sel_q doubles
    // as the pending op code that gets stored alongside the captured result.
    always_comb begin
        accept  = state_q == IDLE && bus.op_valid && count_q < FULL;
        push    = state_q == SETTLE_S && cnt_q == '0;
        pop     = count_q != '0 && bus.res_ready;
        state_d = accept ? SETTLE_S : push ? IDLE : state_q;
        cnt_d   = accept ? CNT_INIT : (state_q == SETTLE_S && !push) ? cnt_q - CW'(1) : cnt_q;
        sel_d   = accept ? bus.op_sel : sel_q;
        wr_d    = push ? (wr_q == PTR_LAST ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d    = pop ? (rd_q == PTR_LAST ? '0 : rd_q + PW'(1)) : rd_q;
        count_d = count_q + NW'(push) - NW'(pop);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (push) mem_q[wr_q] <= {sel_q, bus.mux_out[WIDTH-1], bus.mux_out == '0, bus.mux_out};
        end
    end
    // A slot is reserved at accept time, so a capture never meets a full FIFO.
    assign bus.op_ready                = state_q == IDLE && count_q < FULL;
    assign bus.busy                    = state_q == SETTLE_S;
    assign {bus.sel_in1, bus.sel_in0}  = sel_q;
    assign bus.res_valid               = count_q != '0;
    assign {bus.res_sel, bus.res_neg, bus.res_zero, bus.res_data} = mem_q[rd_q];
endmodule

// File: tb/tb_alu_result_capture_16b.sv
// tb_alu_result_capture_16b: directed scoreboard bench for alu_result_capture_16b (SETTLE=2/DEPTH=2 and SETTLE=1/DEPTH=1 instances).
module tb_alu_result_capture_16b;
    typedef struct packed {
        logic [15:0] d;
        logic        z;
        logic        n;
        logic [1:0]  s;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    exp_t aq[$];
    exp_t bq[$];
    logic [15:0] vals [6] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h1357, 16'hFFFF, 16'h0001};
    alu_result_capture_16b_if #(.WIDTH(16)) aif();
    alu_result_capture_16b_if #(.WIDTH(16)) bif();
    alu_result_capture_16b #(.WIDTH(16), .SETTLE(2), .DEPTH(2)) dut_a (.clk(clk), .rst(rst), .bus(aif));
    alu_result_capture_16b #(.WIDTH(16), .SETTLE(1), .DEPTH(1)) dut_b (.clk(clk), .rst(rst), .bus(bif));
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    function automatic exp_t mk(input logic [1:0] s, input logic [15:0] d);
        exp_t e;
        e.d = d;
        e.z = (d == 16'h0000);
        e.n = d[15];
        e.s = s;
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic check_head(input bit b);
        exp_t e;
        if (b) begin
            if (bq.size() == 0) chk("b_unexpected_pop", 32'd1, 32'd0);
            else begin
                e = bq.pop_front();
                chk("b_res_data", 32'(bif.res_data), 32'(e.d));
                chk("b_res_zero", 32'(bif.res_zero), 32'(e.z));
                chk("b_res_neg", 32'(bif.res_neg), 32'(e.n));
                chk("b_res_sel", 32'(bif.res_sel), 32'(e.s));
            end
        end else begin
            if (aq.size() == 0) chk("a_unexpected_pop", 32'd1, 32'd0);
            else begin
                e = aq.pop_front();
                chk("a_res_data", 32'(aif.res_data), 32'(e.d));
                chk("a_res_zero", 32'(aif.res_zero), 32'(e.z));
                chk("a_res_neg", 32'(aif.res_neg), 32'(e.n));
                chk("a_res_sel", 32'(aif.res_sel), 32'(e.s));
            end
        end
    endtask
    always @(negedge clk) if (!rst && aif.res_valid && aif.res_ready) check_head(1'b0);
    always @(negedge clk) if (!rst && bif.res_valid && bif.res_ready) check_head(1'b1);
    task automatic wait_ready(input bit b);
        int n = 0;
        while (!(b ? bif.op_ready : aif.op_ready) && n < 50) begin
            step();
            n++;
        end
        chk(b ? "b_op_ready_timeout" : "a_op_ready_timeout", 32'(b ? bif.op_ready : aif.op_ready), 32'd1);
    endtask
    // Issue one op, hold it until the accept edge, then wait out the settle window.
    task automatic run_op(input bit b, input logic [1:0] s, input logic [15:0] d);
        wait_ready(b);
        if (b) begin
            bif.op_valid = 1'b1;
            bif.op_sel   = s;
            bif.mux_out  = d;
            bq.push_back(mk(s, d));
        end else begin
            aif.op_valid = 1'b1;
            aif.op_sel   = s;
            aif.mux_out  = d;
            aq.push_back(mk(s, d));
        end
        step();
        aif.op_valid = 1'b0;
        bif.op_valid = 1'b0;
        repeat (b ? 1 : 2) step();
    endtask
    initial begin
        aif.op_valid = 1'b0; aif.op_sel = 2'b00; aif.mux_out = 16'h0; aif.res_ready = 1'b0;
        bif.op_valid = 1'b0; bif.op_sel = 2'b00; bif.mux_out = 16'h0; bif.res_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        #1;
        chk("rst_res_valid", 32'(aif.res_valid), 32'd0);
        chk("rst_res_data", 32'(aif.res_data), 32'd0);
        chk("rst_res_flags", 32'({aif.res_zero, aif.res_neg, aif.res_sel}), 32'd0);
        chk("rst_sel", 32'({aif.sel_in1, aif.sel_in0}), 32'd0);
        chk("rst_busy", 32'(aif.busy), 32'd0);
        chk("rst_op_ready", 32'(aif.op_ready), 32'd1);
        // T1: basic capture latency
        step();
        aif.op_valid = 1'b1; aif.op_sel = 2'b01; aif.mux_out = 16'h1234;
        aq.push_back(mk(2'b01, 16'h1234));
        step();
        aif.op_valid = 1'b0;
        chk("t1_sel_in0", 32'(aif.sel_in0), 32'd1);
        chk("t1_sel_in1", 32'(aif.sel_in1), 32'd0);
        chk("t1_busy", 32'(aif.busy), 32'd1);
        chk("t1_op_ready_settle", 32'(aif.op_ready), 32'd0);
        step();
        chk("t1_valid_early", 32'(aif.res_valid), 32'd0);
        step();
        chk("t1_res_valid", 32'(aif.res_valid), 32'd1);
        chk("t1_res_data", 32'(aif.res_data), 32'h1234);
        chk("t1_res_flags", 32'({aif.res_zero, aif.res_neg}), 32'd0);
        chk("t1_res_sel", 32'(aif.res_sel), 32'd1);
        chk("t1_idle", 32'({aif.busy, aif.op_ready}), 32'b01);
        aif.res_ready = 1'b1;
        step();
        chk("t1_popped", 32'(aif.res_valid), 32'd0);
        // T2: zero and negative flags, popped the cycle after capture
        run_op(1'b0, 2'b11, 16'h0000);
        chk("t2a_valid", 32'(aif.res_valid), 32'd1);
        chk("t2a_zero_neg", 32'({aif.res_zero, aif.res_neg}), 32'b10);
        step();
        chk("t2a_popped", 32'(aif.res_valid), 32'd0);
        run_op(1'b0, 2'b10, 16'h8001);
        chk("t2b_valid", 32'(aif.res_valid), 32'd1);
        chk("t2b_zero_neg", 32'({aif.res_zero, aif.res_neg}), 32'b01);
        step();
        chk("t2b_popped", 32'(aif.res_valid), 32'd0);
        // T3: FIFO full back-pressures op acceptance
        aif.res_ready = 1'b0;
        run_op(1'b0, 2'b00, 16'hAAAA);
        run_op(1'b0, 2'b10, 16'h5555);
        chk("t3_full_op_ready", 32'(aif.op_ready), 32'd0);
        chk("t3_head", 32'(aif.res_data), 32'hAAAA);
        aif.op_valid = 1'b1; aif.op_sel = 2'b01; aif.mux_out = 16'h7777;
        repeat (3) step();
        chk("t3_stalled", 32'({aif.busy, aif.op_ready}), 32'b00);
        chk("t3_sel_held", 32'({aif.sel_in1, aif.sel_in0}), 32'b10);
        aif.res_ready = 1'b1;
        step();
        aif.res_ready = 1'b0;
        chk("t3_op_ready_after_pop", 32'(aif.op_ready), 32'd1);
        aq.push_back(mk(2'b01, 16'h7777));
        step();
        aif.op_valid = 1'b0;
        chk("t3_third_accepted", 32'(aif.busy), 32'd1);
        chk("t3_third_sel", 32'({aif.sel_in1, aif.sel_in0}), 32'b01);
        repeat (2) step();
        chk("t3_head_after_capture", 32'(aif.res_data), 32'h5555);
        aif.res_ready = 1'b1;
        repeat (2) step();
        chk("t3_drained", 32'(aif.res_valid), 32'd0);
        chk("t3_scoreboard_empty", 32'(aq.size()), 32'd0);
        // T4: op/mux changes during settle
        aif.res_ready = 1'b0;
        aif.op_valid = 1'b1; aif.op_sel = 2'b11; aif.mux_out = 16'h1111;
        step();
        aif.op_sel = 2'b10; aif.mux_out = 16'hFFFF;
        chk("t4_sel_after_accept", 32'({aif.sel_in1, aif.sel_in0}), 32'b11);
        step();
        chk("t4_sel_held", 32'({aif.sel_in1, aif.sel_in0}), 32'b11);
        aq.push_back(mk(2'b11, 16'hFFFF));
        step();
        aif.op_valid = 1'b0;
        chk("t4_res_data", 32'(aif.res_data), 32'hFFFF);
        chk("t4_res_sel", 32'(aif.res_sel), 32'b11);
        chk("t4_res_neg", 32'(aif.res_neg), 32'd1);
        chk("t4_sel_after_capture", 32'({aif.sel_in1, aif.sel_in0}), 32'b11);
        // T5: reset in the middle of settle with one entry queued
        aif.op_valid = 1'b1; aif.op_sel = 2'b10; aif.mux_out = 16'h2222;
        step();
        aif.op_valid = 1'b0;
        chk("t5_busy", 32'(aif.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(aif.res_valid), 32'd0);
        chk("t5_rst_sel", 32'({aif.sel_in1, aif.sel_in0}), 32'b00);
        chk("t5_rst_busy", 32'(aif.busy), 32'd0);
        aq.delete();
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("t5_no_capture", 32'(aif.res_valid), 32'd0);
        aif.op_valid = 1'b1; aif.op_sel = 2'b01; aif.mux_out = 16'h1234;
        aq.push_back(mk(2'b01, 16'h1234));
        step();
        aif.op_valid = 1'b0;
        chk("t5_sel_in0", 32'({aif.sel_in1, aif.sel_in0}), 32'b01);
        repeat (2) step();
        chk("t5_res_valid", 32'(aif.res_valid), 32'd1);
        chk("t5_res_data", 32'(aif.res_data), 32'h1234);
        aif.res_ready = 1'b1;
        step();
        chk("t5_popped", 32'(aif.res_valid), 32'd0);
        // T6: SETTLE=1, DEPTH=1 stream with pointer wrap
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, 2'(i), vals[i]);
            chk("t6_captured", 32'(bif.res_valid), 32'd1);
            chk("t6_full_op_ready", 32'(bif.op_ready), 32'd0);
        end
        for (int n = 0; n < 20 && bq.size() != 0; n++) step();
        step();
        chk("t6_all_delivered", 32'(bq.size()), 32'd0);
        chk("t6_drained", 32'(bif.res_valid), 32'd0);
        chk("a_scoreboard_empty", 32'(aq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
